fc_l2_port_arbiter: RTL and testbench
=====================================

Name: fc_l2_port_arbiter

Overview:
- Shares the single fabric-controller L2 data master port between N_PORTS TCDM-style requesters: core data port (index 0) and HWPE master ports (1..N_PORTS-1).
- Round-robin arbitration on the request channel.
- Outstanding-transaction ID FIFO routes in-order responses back to the originating requester.
- Sits between the FC core / fc_hwpe and the SoC interconnect L2 port inside the FC subsystem.

Parameters:
- N_PORTS, 5, number of requesters (≥2); port 0 is the core.
- MAX_OUTSTANDING, 4, ID FIFO depth = max granted-but-unanswered transactions (power of 2, ≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- s_req_i  in  N_PORTS  per-requester request.
- s_add_i  in  N_PORTS x ADDR_WIDTH  address.
- s_wen_i  in  N_PORTS  write-enable, active low (1 = read).
- s_wdata_i  in  N_PORTS x DATA_WIDTH  write data.
- s_be_i  in  N_PORTS x DATA_WIDTH/8  byte enables.
- s_gnt_o  out  N_PORTS  per-requester grant.
- s_r_valid_o  out  N_PORTS  per-requester response valid.
- s_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- s_r_opc_o  out  1  response error, broadcast.
- m_req_o  out  1  L2 request.
- m_add_o  out  ADDR_WIDTH  L2 address.
- m_wen_o  out  1  L2 write-enable, active low.
- m_wdata_o  out  DATA_WIDTH  L2 write data.
- m_be_o  out  DATA_WIDTH/8  L2 byte enables.
- m_gnt_i  in  1  L2 grant.
- m_r_valid_i  in  1  L2 response valid.
- m_r_rdata_i  in  DATA_WIDTH  L2 read data.
- m_r_opc_i  in  1  L2 response error.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_unexp_rsp_o  out  1  sticky flag: response arrived with empty FIFO.

Behaviour:
- Reset values:
  - rr_ptr = 0, lock = 0, FIFO empty.
  - All outputs 0, including m_req_o, s_gnt_o, s_r_valid_o, outstanding_o and err_unexp_rsp_o.
- Arbitration is combinational, zero-latency:
  - Winner = first requester with s_req_i set, searching from rr_ptr upward with wrap.
  - m_req_o = (any s_req_i) & ~fifo_full.
  - Master request fields are muxed from the winner.
  - s_gnt_o[winner] = m_gnt_i & m_req_o; all other grants are 0.
- Lock:
  - If m_req_o=1 and m_gnt_i=0, the winner index is registered (locked).
  - Next cycle the locked port is forced as winner while its s_req_i stays high.
  - Lock releases on grant.
  - If the locked requester deasserts s_req_i (protocol violation), the lock releases and normal arbitration resumes the same cycle.
- Pointer: on a grant, rr_ptr ← winner+1, modulo N_PORTS.
- Handshake events:
  - Grant (m_req_o & m_gnt_i): push the winner index into the FIFO.
  - m_r_valid_i: pop the FIFO head. Drive s_r_valid_o[head]=1, s_r_rdata_o=m_r_rdata_i, s_r_opc_o=m_r_opc_i, all in the same cycle (combinational passthrough).
- Boundary cases:
  - Push and pop in the same cycle: allowed; occupancy is unchanged.
  - Full: m_req_o is forced 0 and no grant is issued, even if a pop occurs that cycle. This avoids a combinational path from m_r_valid_i to m_req_o.
  - r_valid with empty FIFO: response is dropped, all s_r_valid_o stay 0, err_unexp_rsp_o is set and cleared only by reset.
  - A response never arrives earlier than one cycle after its grant.
  - Reset mid-transaction: FIFO, lock and pointer are cleared; late responses set the error flag.

Optional Feature:
- Macro: FC_L2_ARB_CORE_PRIO_EN.
- Defined:
  - Port 0 (core) has fixed priority over round-robin.
  - After 4 consecutive port-0 grants while any other s_req_i is pending, the next arbitration excludes port 0 for one grant.
  - The consecutive-grant counter clears on any non-port-0 grant or when no other requests are pending.
- Undefined: pure round-robin over all ports, and no counter is instantiated.

Decomposition:
- Package fc_l2_arb_pkg holds:
  - port_idx_t, width clog2(N_PORTS).
  - occ_t.
  - CORE_PORT = 0.
  - STARVE_LIMIT = 4.
- Sub-module fc_l2_arb_id_fifo: synchronous FIFO of port_idx_t with push, pop, full, empty and occupancy outputs.
- Arbitration logic stays in the top level.

Test Plan:
- Ports 1 and 3 request together with rr_ptr=0 and m_gnt_i=1 → port 1 granted in cycle 0, port 3 in cycle 1; rr_ptr=4 after.
- Port 2 requests with m_gnt_i=0 for 3 cycles, port 0 then requests → port 2 stays muxed (lock) until granted; port 0 is granted next.
- 4 reads granted with no responses (MAX_OUTSTANDING=4) → m_req_o=0 and outstanding_o=4. One r_valid → returned to the first granter; m_req_o reasserts the next cycle.
- Grants to ports 4,1,2, then three r_valid with rdata 0xA,0xB,0xC → s_r_valid_o pulses on ports 4,1,2 carrying 0xA,0xB,0xC; m_r_opc_i=1 on the second → s_r_opc_o=1 for port 1 only.
- r_valid with empty FIFO → no s_r_valid_o and err_unexp_rsp_o=1; reset → cleared.
- With FC_L2_ARB_CORE_PRIO_EN, ports 0 and 2 requesting continuously → grant sequence 0,0,0,0,2,0,0,0,0,2.

Source files
------------

// File: rtl/fc_l2_arb_pkg.sv
// Shared types and constants for the FC L2 port arbiter.
package fc_l2_arb_pkg;
    localparam int N_PORTS_DEF         = 5;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int CORE_PORT           = 0;
    localparam int STARVE_LIMIT        = 4;

    typedef logic [$clog2(N_PORTS_DEF)-1:0]       port_idx_t;
    typedef logic [$clog2(MAX_OUTSTANDING_DEF):0] occ_t;
endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// Outstanding-transaction FIFO holding the requester index of each granted
// L2 access, so in-order responses can be routed back.
module fc_l2_arb_id_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (!do_push && do_pop) count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing the FC L2 data master port among N_PORTS requesters.
// Optional core-priority mode: define FC_L2_ARB_CORE_PRIO_EN.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int N_PORTS         = N_PORTS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [N_PORTS-1:0]                     s_req_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     s_add_i,
    input  logic [N_PORTS-1:0]                     s_wen_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]   s_be_i,
    output logic [N_PORTS-1:0]                     s_gnt_o,
    output logic [N_PORTS-1:0]                     s_r_valid_o,
    output logic [DATA_WIDTH-1:0]                  s_r_rdata_o,
    output logic                                   s_r_opc_o,
    output logic                                   m_req_o,
    output logic [ADDR_WIDTH-1:0]                  m_add_o,
    output logic                                   m_wen_o,
    output logic [DATA_WIDTH-1:0]                  m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                m_be_o,
    input  logic                                   m_gnt_i,
    input  logic                                   m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                  m_r_rdata_i,
    input  logic                                   m_r_opc_i,
    output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
    output logic                                   err_unexp_rsp_o
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t               rr_ptr;
    idx_t               lock_idx;
    idx_t               winner;
    idx_t               head;
    logic               lock;
    logic               fifo_full;
    logic               fifo_empty;
    logic               grant;
    logic               rsp_hit;
    logic [N_PORTS-1:0] req_arb;
    int                 cand;

`ifdef FC_L2_ARB_CORE_PRIO_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0]   core_cnt;
    logic               starve;
    logic               others_pending;

    assign starve         = (core_cnt == CNT_W'(STARVE_LIMIT));
    assign others_pending = |(s_req_i & ~(N_PORTS'(1) << CORE_PORT));
`endif

    // Reverse scan so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        req_arb = s_req_i;
`ifdef FC_L2_ARB_CORE_PRIO_EN
        if (starve) req_arb[CORE_PORT] = 1'b0;
`endif
        winner = '0;
        cand   = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            if (req_arb[cand]) winner = idx_t'(cand);
        end
`ifdef FC_L2_ARB_CORE_PRIO_EN
        if (req_arb[CORE_PORT]) winner = idx_t'(CORE_PORT);
`endif
        if (lock && s_req_i[lock_idx]) winner = lock_idx;
    end

    // Full blocks requests regardless of a same-cycle pop, keeping r_valid off the req path.
    assign m_req_o   = (|s_req_i) & ~fifo_full;
    assign grant     = m_req_o & m_gnt_i;
    assign s_gnt_o   = grant ? (N_PORTS'(1) << winner) : '0;
    assign m_add_o   = m_req_o ? s_add_i[winner]   : '0;
    assign m_wen_o   = m_req_o ? s_wen_i[winner]   : 1'b0;
    assign m_wdata_o = m_req_o ? s_wdata_i[winner] : '0;
    assign m_be_o    = m_req_o ? s_be_i[winner]    : '0;

    assign rsp_hit     = m_r_valid_i & ~fifo_empty;
    assign s_r_valid_o = rsp_hit ? (N_PORTS'(1) << head) : '0;
    assign s_r_rdata_o = rsp_hit ? m_r_rdata_i : '0;
    assign s_r_opc_o   = rsp_hit ? m_r_opc_i : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr          <= '0;
            lock            <= 1'b0;
            lock_idx        <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            lock     <= m_req_o & ~m_gnt_i;
            lock_idx <= winner;
            if (grant) rr_ptr <= (winner == idx_t'(N_PORTS - 1)) ? '0 : winner + idx_t'(1);
            if (m_r_valid_i && fifo_empty) err_unexp_rsp_o <= 1'b1;
        end
    end

`ifdef FC_L2_ARB_CORE_PRIO_EN
    // Consecutive core grants while others wait; saturates at the starvation limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_cnt <= '0;
        end else if (!others_pending) begin
            core_cnt <= '0;
        end else if (grant) begin
            if (winner != idx_t'(CORE_PORT)) core_cnt <= '0;
            else if (!starve)                core_cnt <= core_cnt + CNT_W'(1);
        end
    end
`endif

    fc_l2_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (grant),
        .push_data (winner),
        .pop       (m_r_valid_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (outstanding_o)
    );
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Self-checking bench for fc_l2_port_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fc_l2_port_arbiter;
    import fc_l2_arb_pkg::*;

    localparam int N  = 5;
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         s_req;
    logic [N-1:0][AW-1:0] s_add;
    logic [N-1:0]         s_wen;
    logic [N-1:0][DW-1:0] s_wdata;
    logic [N-1:0][BW-1:0] s_be;
    logic [N-1:0]         s_gnt_o;
    logic [N-1:0]         s_r_valid_o;
    logic [DW-1:0]        s_r_rdata_o;
    logic                 s_r_opc_o;
    logic                 m_req_o;
    logic [AW-1:0]        m_add_o;
    logic                 m_wen_o;
    logic [DW-1:0]        m_wdata_o;
    logic [BW-1:0]        m_be_o;
    logic                 m_gnt;
    logic                 m_rvalid;
    logic [DW-1:0]        m_rdata;
    logic                 m_ropc;
    logic [2:0]           outstanding_o;
    logic                 err_o;

    fc_l2_port_arbiter #(
        .N_PORTS(N), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata), .s_be_i(s_be),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
        .m_gnt_i(m_gnt), .m_r_valid_i(m_rvalid), .m_r_rdata_i(m_rdata), .m_r_opc_i(m_ropc),
        .outstanding_o(outstanding_o), .err_unexp_rsp_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of requester ids awaiting a response.
    int           mq[$];
    int           m_ptr;
    int           m_lock_port;
    int           m_cnt;
    bit           m_lock;
    bit           m_err;
    bit           exp_mreq;
    int           exp_w;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rvalid;

    function automatic int model_winner();
        logic [N-1:0] cand;
        cand = s_req;
        if (m_lock && s_req[m_lock_port]) return m_lock_port;
`ifdef FC_L2_ARB_CORE_PRIO_EN
        if (m_cnt >= STARVE_LIMIT) cand[CORE_PORT] = 1'b0;
        else if (cand[CORE_PORT]) return CORE_PORT;
`endif
        for (int k = 0; k < N; k++) if (cand[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ptr = 0; m_lock_port = 0; m_cnt = 0; m_lock = 1'b0; m_err = 1'b0;
    endtask

    task automatic drive_idle();
        s_req = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_ropc = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_add[i]   = 32'hA000_0000 + 32'(i) * 32'h100;
            s_wdata[i] = 32'h5000_0000 + 32'(i);
            s_wen[i]   = 1'(i % 2);
            s_be[i]    = 4'hF;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Inputs are driven 1 unit after posedge; expectations formed at +2.
    task automatic settle();
        #1;
        exp_mreq   = (|s_req) && (mq.size() < MO);
        exp_w      = model_winner();
        exp_gnt    = (exp_mreq && m_gnt) ? (N'(1) << exp_w) : '0;
        exp_rvalid = (m_rvalid && mq.size() > 0) ? (N'(1) << mq[0]) : '0;
    endtask

    task automatic tick();
        bit grant;
`ifdef FC_L2_ARB_CORE_PRIO_EN
        bit others;
        others = |s_req[N-1:1];
`endif
        grant = exp_mreq && m_gnt;
        @(posedge clk);
        if (m_rvalid) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1'b1;
        end
        if (grant) begin
            mq.push_back(exp_w);
            m_ptr = (exp_w + 1) % N;
        end
        m_lock      = exp_mreq && !m_gnt;
        m_lock_port = exp_w;
`ifdef FC_L2_ARB_CORE_PRIO_EN
        if (!others) m_cnt = 0;
        else if (grant) m_cnt = (exp_w == CORE_PORT) ? ((m_cnt < STARVE_LIMIT) ? m_cnt + 1 : m_cnt) : 0;
`endif
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (m_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mreq: got %b want 0", m_req_o); end
        n_vec++; if (s_gnt_o !== '0) begin n_err++; $display("[TB] FAIL rst_gnt: got %b want 0", s_gnt_o); end
        n_vec++; if (s_r_valid_o !== '0) begin n_err++; $display("[TB] FAIL rst_rvalid: got %b want 0", s_r_valid_o); end
        n_vec++; if (outstanding_o !== 3'd0) begin n_err++; $display("[TB] FAIL rst_outst: got %0d want 0", outstanding_o); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_err: got %b want 0", err_o); end
        rst_n = 1'b1;
        model_reset();
        m_rvalid = 1'b1; settle(); tick(); m_rvalid = 1'b0;
        s_req = 5'b00100; m_gnt = 1'b1; settle(); tick();
        s_req = '0; m_gnt = 1'b0;
        n_vec++; if (outstanding_o !== 3'd1 || err_o !== 1'b1) begin n_err++; $display("[TB] FAIL pre_async: outst=%0d err=%b want 1/1", outstanding_o, err_o); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin n_err++; $display("[TB] FAIL async_rst: outst=%0d err=%b want 0/0", outstanding_o, err_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        s_req = 5'b10010; m_gnt = 1'b1; settle();
        n_vec++; if (s_gnt_o !== 5'b00010) begin n_err++; $display("[TB] FAIL rst_ptr: got %b want 00010", s_gnt_o); end
        tick();
    endtask

    task automatic test_rr_basic();
        do_reset();
        s_req = 5'b01010; m_gnt = 1'b1; settle();
        n_vec++; if (s_gnt_o !== 5'b00010) begin n_err++; $display("[TB] FAIL rr_first: got %b want 00010", s_gnt_o); end
        n_vec++; if (m_add_o !== s_add[1]) begin n_err++; $display("[TB] FAIL rr_addr: got %h want %h", m_add_o, s_add[1]); end
        tick();
        s_req = 5'b01000; settle();
        n_vec++; if (s_gnt_o !== 5'b01000) begin n_err++; $display("[TB] FAIL rr_second: got %b want 01000", s_gnt_o); end
        tick();
        s_req = 5'b11111; settle();
        n_vec++; if (s_gnt_o !== 5'b10000) begin n_err++; $display("[TB] FAIL rr_ptr4: got %b want 10000", s_gnt_o); end
        tick();
        s_req = 5'b11111; settle();
        n_vec++; if (s_gnt_o !== 5'b00001) begin n_err++; $display("[TB] FAIL rr_wrap: got %b want 00001", s_gnt_o); end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        s_req = 5'b00100; m_gnt = 1'b0; settle();
        n_vec++; if (m_req_o !== 1'b1 || m_add_o !== s_add[2]) begin n_err++; $display("[TB] FAIL lock_start: req=%b addr=%h want 1/%h", m_req_o, m_add_o, s_add[2]); end
        tick();
        s_req = 5'b00101;
        repeat (2) begin
            settle();
            n_vec++; if (m_add_o !== s_add[2] || s_gnt_o !== '0) begin n_err++; $display("[TB] FAIL lock_hold: addr=%h gnt=%b want %h/0", m_add_o, s_gnt_o, s_add[2]); end
            tick();
        end
        m_gnt = 1'b1; settle();
        n_vec++; if (s_gnt_o !== 5'b00100) begin n_err++; $display("[TB] FAIL lock_gnt: got %b want 00100", s_gnt_o); end
        tick();
        s_req = 5'b00001; settle();
        n_vec++; if (s_gnt_o !== 5'b00001) begin n_err++; $display("[TB] FAIL lock_next: got %b want 00001", s_gnt_o); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        s_req = 5'b11110; m_gnt = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            n_vec++; if (s_gnt_o !== (N'(1) << i)) begin n_err++; $display("[TB] FAIL fill_gnt%0d: got %b want %b", i, s_gnt_o, N'(1) << i); end
            tick();
        end
        settle();
        n_vec++; if (m_req_o !== 1'b0 || outstanding_o !== 3'd4 || s_gnt_o !== '0) begin n_err++; $display("[TB] FAIL full_block: req=%b outst=%0d gnt=%b want 0/4/0", m_req_o, outstanding_o, s_gnt_o); end
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h1234; settle();
        n_vec++; if (s_r_valid_o !== 5'b00010 || m_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL full_pop: rvalid=%b req=%b want 00010/0", s_r_valid_o, m_req_o); end
        tick();
        m_rvalid = 1'b0; settle();
        n_vec++; if (m_req_o !== 1'b1 || outstanding_o !== 3'd3 || s_gnt_o !== 5'b00010) begin n_err++; $display("[TB] FAIL full_resume: req=%b outst=%0d gnt=%b want 1/3/00010", m_req_o, outstanding_o, s_gnt_o); end
        tick();
    endtask

    task automatic test_response_routing();
        int          ports[3] = '{4, 1, 2};
        logic [31:0] data[3]  = '{32'hA, 32'hB, 32'hC};
        logic        opc[3]   = '{1'b0, 1'b1, 1'b0};
        do_reset();
        m_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_req = N'(1) << ports[i]; settle(); tick();
        end
        s_req = '0; m_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_rvalid = 1'b1; m_rdata = data[i]; m_ropc = opc[i]; settle();
            n_vec++; if (s_r_valid_o !== (N'(1) << ports[i]) || s_r_rdata_o !== data[i] || s_r_opc_o !== opc[i]) begin
                n_err++; $display("[TB] FAIL route%0d: rvalid=%b data=%h opc=%b want %b/%h/%b", i, s_r_valid_o, s_r_rdata_o, s_r_opc_o, N'(1) << ports[i], data[i], opc[i]);
            end
            tick();
        end
        m_rvalid = 1'b0; m_ropc = 1'b0;
    endtask

    task automatic test_unexpected();
        do_reset();
        m_rvalid = 1'b1; m_rdata = 32'hDEAD; settle();
        n_vec++; if (s_r_valid_o !== '0) begin n_err++; $display("[TB] FAIL unexp_drop: got %b want 0", s_r_valid_o); end
        tick();
        m_rvalid = 1'b0; settle();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("[TB] FAIL unexp_err: got %b want 1", err_o); end
        tick(); settle();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("[TB] FAIL unexp_sticky: got %b want 1", err_o); end
        tick();
        s_req = 5'b00001; m_gnt = 1'b1; settle(); tick();
        do_reset();
        m_rvalid = 1'b1; settle();
        n_vec++; if (s_r_valid_o !== '0 || err_o !== 1'b0 || outstanding_o !== 3'd0) begin n_err++; $display("[TB] FAIL late_rsp: rvalid=%b err=%b outst=%0d want 0/0/0", s_r_valid_o, err_o, outstanding_o); end
        tick();
        m_rvalid = 1'b0; settle();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("[TB] FAIL late_err: got %b want 1", err_o); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            s_req = N'($urandom_range(0, 31));
            for (int i = 0; i < N; i++) begin
                s_add[i] = $urandom; s_wdata[i] = $urandom;
                s_be[i] = BW'($urandom); s_wen[i] = 1'($urandom_range(0, 1));
            end
            m_gnt    = ($urandom_range(0, 9) < 7);
            m_rvalid = (mq.size() > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 39) == 0);
            m_rdata  = $urandom;
            m_ropc   = 1'($urandom_range(0, 1));
            settle();
            n_vec++; if (m_req_o !== exp_mreq) begin n_err++; $display("[TB] FAIL rnd_req c%0d: got %b want %b", c, m_req_o, exp_mreq); end
            n_vec++; if (s_gnt_o !== exp_gnt) begin n_err++; $display("[TB] FAIL rnd_gnt c%0d: got %b want %b", c, s_gnt_o, exp_gnt); end
            if (exp_mreq) begin
                n_vec++; if (m_add_o !== s_add[exp_w] || m_wen_o !== s_wen[exp_w] || m_wdata_o !== s_wdata[exp_w] || m_be_o !== s_be[exp_w]) begin
                    n_err++; $display("[TB] FAIL rnd_mux c%0d: addr=%h wen=%b wdata=%h be=%h want port %0d", c, m_add_o, m_wen_o, m_wdata_o, m_be_o, exp_w);
                end
            end
            n_vec++; if (s_r_valid_o !== exp_rvalid) begin n_err++; $display("[TB] FAIL rnd_rvalid c%0d: got %b want %b", c, s_r_valid_o, exp_rvalid); end
            if (exp_rvalid != '0) begin
                n_vec++; if (s_r_rdata_o !== m_rdata || s_r_opc_o !== m_ropc) begin n_err++; $display("[TB] FAIL rnd_rdata c%0d: got %h/%b want %h/%b", c, s_r_rdata_o, s_r_opc_o, m_rdata, m_ropc); end
            end
            n_vec++; if (outstanding_o !== 3'(mq.size())) begin n_err++; $display("[TB] FAIL rnd_outst c%0d: got %0d want %0d", c, outstanding_o, mq.size()); end
            n_vec++; if (err_o !== m_err) begin n_err++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, err_o, m_err); end
            tick();
        end
        drive_idle();
    endtask

`ifdef FC_L2_ARB_CORE_PRIO_EN
    task automatic test_core_prio();
        int           seq[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
        logic [N-1:0] want;
        do_reset();
        s_req = 5'b00101; m_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m_rvalid = (i > 0);
            settle();
            want = N'(1) << seq[i];
            n_vec++; if (s_gnt_o !== want) begin n_err++; $display("[TB] FAIL prio_seq%0d: got %b want %b", i, s_gnt_o, want); end
            tick();
        end
        drive_idle();
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_rr_basic();
        test_lock();
        test_full();
        test_response_routing();
        test_unexpected();
`ifdef FC_L2_ARB_CORE_PRIO_EN
        test_core_prio();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
